// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: debounced start/stop/clear stopwatch counting ss.hh in BCD from the 1 ms strobe.
// Define STOPWATCH_LAP_EN to build the lap button, which freezes the displayed value while counting continues.
module stopwatch_bcd #(
   parameter int DEB_MS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce1ms,
   input  logic        btn_ss,
   input  logic        btn_clr,
   input  logic        btn_lap,
   output logic [15:0] dat,
   output logic [1:0]  ptr_P,
   output logic        run
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2;
   localparam logic [7:0] DEB_LAST = 8'(DEB_MS - 1);
`ifdef STOPWATCH_LAP_EN
   localparam int NB = 3;
   logic [NB-1:0] btn;
   assign btn = {btn_lap, btn_clr, btn_ss};
`else
   localparam int NB = 2;
   logic [NB-1:0] btn;
   logic unused_lap;
   assign btn = {btn_clr, btn_ss};
   assign unused_lap = btn_lap;
`endif
   logic [NB-1:0] prs;
   for (genvar i = 0; i < NB; i++) begin : g_deb
      logic s1, s2, lvl, lvl_d;
      logic [7:0] cnt;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            lvl <= 1'b0;
            lvl_d <= 1'b0;
            cnt <= '0;
         end else begin
            s1 <= btn[i];
            s2 <= s1;
            lvl_d <= lvl;
            if (ce1ms) begin
               if (s2 == lvl)
                  cnt <= '0;
               else if (cnt == DEB_LAST) begin
                  lvl <= s2;
                  cnt <= '0;
               end else
                  cnt <= cnt + 8'd1;
            end
         end
      assign prs[i] = lvl & ~lvl_d;
   end
   logic ss_p, clr_p, tick, clear;
   logic [1:0] st, st_nx;
   logic [3:0] pre;
   logic [15:0] bcd, bcd_inc, shown;
   logic c0, c1, c2;
   assign ss_p = prs[0];
   assign clr_p = prs[1];
   // clr takes priority over ss only in STOP; elsewhere clr is ignored
   assign st_nx = (st == IDLE) ? (ss_p ? RUN : IDLE)
                : (st == RUN)  ? (ss_p ? STOP : RUN)
                : clr_p ? IDLE : ss_p ? RUN : STOP;
   assign tick = (st == RUN) & ce1ms & (pre == 4'd9);
   assign clear = (st == STOP) & clr_p;
   function automatic logic [3:0] step(input logic [3:0] d, input logic [3:0] top, input logic en);
      return en ? ((d >= top) ? 4'd0 : d + 4'd1) : d;
   endfunction
   assign c0 = bcd[3:0] == 4'd9;
   assign c1 = c0 & (bcd[7:4] == 4'd9);
   assign c2 = c1 & (bcd[11:8] == 4'd9);
   assign bcd_inc = {step(bcd[15:12], 4'd5, c2), step(bcd[11:8], 4'd9, c1),
                     step(bcd[7:4], 4'd9, c0), step(bcd[3:0], 4'd9, 1'b1)};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= IDLE;
         pre <= '0;
         bcd <= '0;
         dat <= '0;
      end else begin
         st <= st_nx;
         pre <= clear ? 4'd0 : ((st == RUN) && ce1ms) ? ((pre >= 4'd9) ? 4'd0 : pre + 4'd1) : pre;
         bcd <= clear ? 16'd0 : tick ? bcd_inc : bcd;
         dat <= shown;
      end
`ifdef STOPWATCH_LAP_EN
   logic frz;
   logic [15:0] lap;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         frz <= 1'b0;
         lap <= '0;
      end else if ((st == RUN) && (st_nx != RUN))
         frz <= 1'b0;
      else if ((st == RUN) && prs[2]) begin
         frz <= ~frz;
         lap <= bcd;
      end
   assign shown = frz ? lap : bcd;
`else
   assign shown = bcd;
`endif
   assign ptr_P = 2'd2;
   assign run = st == RUN;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed vector table plus hand-written bounce, wrap and reset sequences.
// Lap expectations follow STOPWATCH_LAP_EN when it is defined for the build.
module tb_stopwatch_bcd;
   logic clk = 1'b0, rst_n = 1'b0, ce1ms = 1'b0;
   logic btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
   logic [15:0] dat;
   logic [1:0] ptr_P;
   logic run;
   int n_chk = 0, n_fail = 0;
   typedef struct {
      logic ss, clr, lap;
      int ms;
      logic [15:0] dat, dat_lap;
      logic run;
      string name;
   } vec_t;
   vec_t tv[18];
   int nv = 0;
   stopwatch_bcd #(.DEB_MS(10)) dut (
      .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .btn_ss(btn_ss), .btn_clr(btn_clr),
      .btn_lap(btn_lap), .dat(dat), .ptr_P(ptr_P), .run(run)
   );
   always #10 clk = ~clk;
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic ms(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk) ce1ms = 1'b1;
         @(negedge clk) ce1ms = 1'b0;
      end
   endtask
   task automatic fast(input int n);
      @(negedge clk) ce1ms = 1'b1;
      repeat (n) @(negedge clk);
      ce1ms = 1'b0;
   endtask
   task automatic press(input logic s, input logic c, input logic l);
      @(negedge clk);
      btn_ss = s;
      btn_clr = c;
      btn_lap = l;
      repeat (3) @(negedge clk);
      ms(10);
      btn_ss = 1'b0;
      btn_clr = 1'b0;
      btn_lap = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic add(input logic s, input logic c, input logic l, input int m,
                      input logic [15:0] d, input logic [15:0] dl, input logic r, input string nm);
      tv[nv].ss = s;
      tv[nv].clr = c;
      tv[nv].lap = l;
      tv[nv].ms = m;
      tv[nv].dat = d;
      tv[nv].dat_lap = dl;
      tv[nv].run = r;
      tv[nv].name = nm;
      nv++;
   endtask
   initial begin
      add(1, 0, 0, 1234, 16'h0123, 16'h0123, 1, "start");
      add(0, 0, 0, 5,    16'h0123, 16'h0123, 1, "pre9");
      add(0, 0, 0, 1,    16'h0124, 16'h0124, 1, "tick6");
      add(1, 0, 0, 0,    16'h0125, 16'h0125, 0, "stop");
      add(0, 0, 0, 20,   16'h0125, 16'h0125, 0, "frozen");
      add(0, 1, 0, 12,   16'h0000, 16'h0000, 0, "clear");
      add(1, 0, 0, 20,   16'h0002, 16'h0002, 1, "restart");
      add(1, 1, 0, 12,   16'h0003, 16'h0003, 0, "sim_run");
      add(1, 1, 0, 12,   16'h0000, 16'h0000, 0, "sim_stop");
      add(1, 0, 0, 1490, 16'h0149, 16'h0149, 1, "lap_pre");
      add(0, 0, 1, 0,    16'h0150, 16'h0150, 1, "lap_cap");
      add(0, 0, 0, 1490, 16'h0299, 16'h0150, 1, "lap_frz");
      add(0, 0, 1, 0,    16'h0300, 16'h0300, 1, "lap_rel");
      add(0, 0, 0, 10,   16'h0301, 16'h0301, 1, "lap_live");
      add(0, 0, 1, 10,   16'h0303, 16'h0302, 1, "lap2_cap");
      add(1, 0, 0, 0,    16'h0304, 16'h0304, 0, "exit_rel");
      add(0, 0, 1, 0,    16'h0304, 16'h0304, 0, "lap_stop");
      add(0, 1, 0, 12,   16'h0000, 16'h0000, 0, "clear2");
      repeat (3) @(negedge clk);
      chk("rst_dat", dat, 16'h0000);
      chk("rst_ptr", {14'd0, ptr_P}, 16'd2);
      chk("rst_run", {15'd0, run}, 16'd0);
      rst_n = 1'b1;
      ms(20);
      repeat (2) @(negedge clk);
      chk("idle_dat", dat, 16'h0000);
      chk("idle_run", {15'd0, run}, 16'd0);
      for (int i = 0; i < nv; i++) begin
         if (tv[i].ss | tv[i].clr | tv[i].lap) press(tv[i].ss, tv[i].clr, tv[i].lap);
         ms(tv[i].ms);
         repeat (2) @(negedge clk);
`ifdef STOPWATCH_LAP_EN
         chk({tv[i].name, "_dat"}, dat, tv[i].dat_lap);
`else
         chk({tv[i].name, "_dat"}, dat, tv[i].dat);
`endif
         chk({tv[i].name, "_run"}, {15'd0, run}, {15'd0, tv[i].run});
      end
      for (int i = 0; i < 3; i++) begin
         btn_ss = 1'b1;
         ms(3);
         btn_ss = 1'b0;
         ms(3);
      end
      ms(10);
      repeat (2) @(negedge clk);
      chk("bounce_none", {15'd0, run}, 16'd0);
      press(1, 0, 0);
      chk("bounce_run", {15'd0, run}, 16'd1);
      ms(20);
      repeat (2) @(negedge clk);
      chk("bounce_once_dat", dat, 16'h0002);
      chk("bounce_once_run", {15'd0, run}, 16'd1);
      press(1, 0, 0);
      chk("bounce_stop", dat, 16'h0003);
      press(0, 1, 0);
      chk("clear3", dat, 16'h0000);
      press(1, 0, 0);
      fast(59980);
      repeat (2) @(negedge clk);
      chk("wrap_5998", dat, 16'h5998);
      for (int i = 0; i < 20; i++) begin
         ms(1);
         repeat (2) @(negedge clk);
         chk("digit_range", {15'd0, dat[15:12] <= 4'd5 && dat[11:8] <= 4'd9 && dat[7:4] <= 4'd9 && dat[3:0] <= 4'd9}, 16'd1);
         if (i == 9) chk("wrap_5999", dat, 16'h5999);
         if (i == 19) chk("wrap_0000", dat, 16'h0000);
      end
      ms(37);
      repeat (2) @(negedge clk);
      chk("wrap_cont", dat, 16'h0003);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_dat", dat, 16'h0000);
      chk("midrst_run", {15'd0, run}, 16'd0);
      chk("midrst_ptr", {14'd0, ptr_P}, 16'd2);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ms(30);
      repeat (2) @(negedge clk);
      chk("postrst_dat", dat, 16'h0000);
      chk("postrst_run", {15'd0, run}, 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
